sort_fsm: RTL



---
 rtl/sort_fsm_if.sv | 23 ++
 rtl/sort_fsm.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sort_fsm_if.sv
// Control/status bundle between the sort FSM and its 4-entry sort datapath.
// The master side is the FSM; the slave side is the datapath/host environment.
interface sort_fsm_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic [2:0]       LT;
  logic [5:0]       SEL;
  logic [3:0]       LD;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] SWAP_CNT;

  modport master (
    input  START, LT,
    output SEL, LD, BUSY, DONE, SWAP_CNT
  );

  modport slave (
    output START, LT,
    input  SEL, LD, BUSY, DONE, SWAP_CNT
  );
endinterface

// File: rtl/sort_fsm.sv
// Bubble-sort control FSM: loads the switch word, then runs compare/swap passes
// leaving arr_0..arr_3 descending. Define EARLY_EXIT_EN to stop after a swap-free pass.
module sort_fsm #(
  parameter int NUM_PASSES = 3,
  parameter int CNT_W      = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  sort_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP0,
    S_CMP1,
    S_CMP2,
    S_DONE
  } state_e;

  localparam int PASS_W = 4;

  state_e             state_q, state_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic               swap_flag_q, swap_flag_d;
  logic [CNT_W-1:0]   swap_cnt_q, swap_cnt_d;
  logic [5:0]         sel;
  logic [3:0]         ld;
  logic               step_lt;

  // LT bit belonging to the compare step currently in progress.
  assign step_lt = ((state_q == S_CMP0) && bus.LT[0]) ||
                   ((state_q == S_CMP1) && bus.LT[1]) ||
                   ((state_q == S_CMP2) && bus.LT[2]);

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d     = state_q;
    pass_d      = pass_q;
    swap_flag_d = swap_flag_q;
    swap_cnt_d  = swap_cnt_q;
    sel         = 6'b000000;
    ld          = 4'b0000;

    if (step_lt) begin
      swap_flag_d = 1'b1;
      if (swap_cnt_q != '1) swap_cnt_d = swap_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d     = S_LOAD;
          pass_d      = '0;
          swap_flag_d = 1'b0;
          swap_cnt_d  = '0;
        end
      end
      S_LOAD: begin
        ld          = 4'b1111;
        pass_d      = '0;
        swap_flag_d = 1'b0;
        swap_cnt_d  = '0;
        state_d     = S_CMP0;
      end
      S_CMP0: begin
        if (bus.LT[0]) begin
          sel = 6'b000011;
          ld  = 4'b0011;
        end
        state_d = S_CMP1;
      end
      S_CMP1: begin
        if (bus.LT[1]) begin
          sel = 6'b010100;
          ld  = 4'b0110;
        end
        state_d = S_CMP2;
      end
      S_CMP2: begin
        if (bus.LT[2]) begin
          sel = 6'b101000;
          ld  = 4'b1100;
        end
        pass_d = pass_q + 1'b1;
        if (pass_d == PASS_W'(NUM_PASSES)) begin
          state_d = S_DONE;
`ifdef EARLY_EXIT_EN
        end else if (!(swap_flag_q || bus.LT[2])) begin
          state_d = S_DONE;
`endif
        end else begin
          state_d     = S_CMP0;
          swap_flag_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= S_IDLE;
      pass_q      <= '0;
      swap_flag_q <= 1'b0;
      swap_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      pass_q      <= pass_d;
      swap_flag_q <= swap_flag_d;
      swap_cnt_q  <= swap_cnt_d;
    end
  end

  assign bus.SEL      = sel;
  assign bus.LD       = ld;
  assign bus.BUSY     = (state_q == S_LOAD) || (state_q == S_CMP0) ||
                        (state_q == S_CMP1) || (state_q == S_CMP2);
  assign bus.DONE     = (state_q == S_DONE);
  assign bus.SWAP_CNT = swap_cnt_q;

endmodule
